// File: rtl/ultra_sonic_pkg.sv
// Shared types and helpers for the ultrasonic ranger array.
// Holds the FSM states, result layout and round-robin channel search.
package ultra_sonic_pkg;

    localparam int RES_TIMEOUT_BIT = 31;
    localparam int RES_FRESH_BIT   = 30;
    localparam int MAX_CH          = 16;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } us_state_t;

    // Field order mirrors RES_TIMEOUT_BIT / RES_FRESH_BIT.
    typedef struct packed {
        logic        timeout;
        logic        fresh;
        logic [29:0] count;
    } us_result_t;

    // First set mask bit above cur, wrapping; cur = 15 yields the lowest.
    function automatic logic [3:0] next_ch(
        input logic [MAX_CH-1:0] mask,
        input logic [3:0]        cur
    );
        logic [3:0] sel;
        logic [3:0] idx;
        sel = cur;
        for (int i = MAX_CH; i >= 1; i--) begin
            idx = cur + 4'(i);
            if (mask[idx]) sel = idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for one asynchronous echo input.
// Synchronous active-low reset clears both stages.
module echo_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultra_sonic_array.sv
// Round-robin HC-SR04 style ranger controller with per-channel
// echo width measurement, timeout detection and readable results.
module ultra_sonic_array
    import ultra_sonic_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int COUNT_WIDTH    = 24,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int HOLDOFF_CYCLES = 3_000_000,
    localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    input  logic [AW-1:0]     read_addr,
    input  logic              read_en,
    output logic [31:0]       read_data,
    output logic              done,
    output logic [AW-1:0]     done_ch
);

    localparam int CW = COUNT_WIDTH;
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    us_state_t state, state_n;
    logic [CW-1:0] timer, timer_n;
    logic [CW-1:0] count, count_n;
    logic [3:0] cur, cur_n;
    logic commit;
    logic commit_to;

    logic [NUM_CH-1:0] echo_s;
    logic [MAX_CH-1:0] echo_pad;
    logic [MAX_CH-1:0] mask_pad;
    logic cur_echo;
    logic go;

    us_result_t res [NUM_CH];
    us_result_t rd;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        echo_sync u_sync (
            .clk     (clk),
            .reset_l (reset_l),
            .d       (echo[g]),
            .q       (echo_s[g])
        );
    end

    assign echo_pad = MAX_CH'(echo_s);
    assign mask_pad = MAX_CH'(ch_mask);
    assign cur_echo = echo_pad[cur];
    assign go       = enable && (|ch_mask);

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        count_n   = count;
        cur_n     = cur;
        commit    = 1'b0;
        commit_to = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_n = TRIG;
                    timer_n = '0;
                    cur_n   = next_ch(mask_pad, 4'hF);
                end
            end
            TRIG: begin
                if (timer == TRIG_LAST) begin
                    state_n = WAIT_RISE;
                    timer_n = '0;
                    count_n = '0;
                end else begin
                    timer_n = timer + CW'(1);
                end
            end
            WAIT_RISE: begin
                timer_n = timer + CW'(1);
                if (timer == TO_LAST) begin
                    commit    = 1'b1;
                    commit_to = 1'b1;
                    state_n   = HOLDOFF;
                    timer_n   = '0;
                end else if (cur_echo) begin
                    state_n = MEASURE;
                    count_n = CW'(1);
                end
            end
            MEASURE: begin
                timer_n = timer + CW'(1);
                if (!cur_echo) begin
                    commit  = 1'b1;
                    state_n = HOLDOFF;
                    timer_n = '0;
                end else if (timer == TO_LAST) begin
                    commit    = 1'b1;
                    commit_to = 1'b1;
                    state_n   = HOLDOFF;
                    timer_n   = '0;
                end else if (count != CNT_MAX) begin
                    count_n = count + CW'(1);
                end
            end
            HOLDOFF: begin
                if (timer == HOLD_LAST) begin
                    timer_n = '0;
                    if (go) begin
                        state_n = TRIG;
                        cur_n   = next_ch(mask_pad, cur);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state   <= IDLE;
            timer   <= '0;
            count   <= '0;
            cur     <= '0;
            done    <= 1'b0;
            done_ch <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            count <= count_n;
            cur   <= cur_n;
            done  <= commit;
            if (commit) done_ch <= cur[AW-1:0];
        end
    end

    always_comb begin
        trigger = '0;
        if (state == TRIG) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cur == 4'(i)) trigger[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (read_addr == AW'(i)) rd = res[i];
        end
    end

    // A commit to the channel being read overrides the fresh clear.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            for (int i = 0; i < NUM_CH; i++) res[i] <= '0;
            read_data <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit && cur == 4'(i)) begin
                    res[i].timeout <= commit_to;
                    res[i].fresh   <= 1'b1;
                    res[i].count   <= 30'(count);
                end else if (read_en && read_addr == AW'(i)) begin
                    res[i].fresh <= 1'b0;
                end
            end
            read_data <= rd;
        end
    end

endmodule

// File: tb/tb_ultra_sonic_array.sv
// Directed bench for ultra_sonic_array with small timing parameters.
// Linear scenario sequence; every check is an immediate assertion.
module tb_ultra_sonic_array;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        enable;
    logic [1:0]  ch_mask;
    logic [1:0]  echo;
    logic [1:0]  trigger;
    logic [0:0]  read_addr;
    logic        read_en;
    logic [31:0] read_data;
    logic        done;
    logic [0:0]  done_ch;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ultra_sonic_array #(
        .NUM_CH         (2),
        .COUNT_WIDTH    (24),
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (100),
        .HOLDOFF_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .echo      (echo),
        .trigger   (trigger),
        .read_addr (read_addr),
        .read_en   (read_en),
        .read_data (read_data),
        .done      (done),
        .done_ch   (done_ch)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a trigger, then check it is the expected one-hot for its width.
    task automatic trig_pulse(input string tag, input logic [1:0] exp,
                              output int gap);
        int w;
        gap = 0;
        while (trigger == 2'b00 && gap < 300) begin
            tick();
            gap++;
        end
        w = 0;
        while (trigger != 2'b00 && w < 20) begin
            check({tag, "_onehot"}, 32'(trigger), 32'(exp));
            tick();
            w++;
        end
        check({tag, "_width"}, 32'(w), 32'd4);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse(input int ch, input int dly, input int wid);
        repeat (dly) tick();
        echo[ch] = 1'b1;
        repeat (wid) tick();
        echo[ch] = 1'b0;
    endtask

    initial begin
        int gap;
        int n;
        int seen;
        logic [31:0] r;

        reset_l   = 1'b0;
        enable    = 1'b0;
        ch_mask   = 2'b00;
        echo      = 2'b00;
        read_addr = 1'b0;
        read_en   = 1'b0;
        repeat (3) tick();
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_ch", 32'(done_ch), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        reset_l = 1'b1;
        tick();
        check("idle_no_trig", 32'(trigger), 32'd0);

        // Single measurement, 37-cycle echo on ch0
        enable  = 1'b1;
        ch_mask = 2'b01;
        trig_pulse("s1", 2'b01, gap);
        check("s1_trig_latency", 32'(gap), 32'd1);
        pulse(0, 5, 37);
        wait_done(n);
        check("s1_done", 32'(done), 32'd1);
        check("s1_done_ch", 32'(done_ch), 32'd0);
        tick();
        check("s1_done_1cyc", 32'(done), 32'd0);
        check("s1_read", read_data, 32'h4000_0025);

        // No echo: timeout 100 cycles after WAIT_RISE entry
        trig_pulse("s2", 2'b01, gap);
        wait_done(n);
        check("s2_to_latency", 32'(n), 32'd100);
        tick();
        check("s2_read", read_data, 32'hC000_0000);

        // Stuck echo
        echo[0] = 1'b1;
        trig_pulse("s3", 2'b01, gap);
        wait_done(n);
        check("s3_to_latency", 32'(n), 32'd100);
        echo[0] = 1'b0;
        trig_pulse("s3n", 2'b01, gap);
        check("s3_holdoff_gap", 32'(gap), 32'd10);
        r = read_data;
        check("s3_flags", 32'(r[31:24]), 32'hC0);
        check("s3_cnt_lt100", 32'(r[23:0] < 24'd100), 32'd1);
        check("s3_cnt_nonzero", 32'(r[23:0] != 24'd0), 32'd1);

        // Round robin: mask sampled at next selection
        ch_mask = 2'b11;
        wait_done(n);
        check("rr0_to_latency", 32'(n), 32'd100);
        trig_pulse("rr1", 2'b10, gap);
        check("rr1_gap", 32'(gap), 32'd10);
        pulse(1, 3, 20);
        wait_done(n);
        check("rr1_done", 32'(done), 32'd1);
        check("rr1_done_ch", 32'(done_ch), 32'd1);
        read_addr = 1'b1;
        tick();
        check("rr1_read", read_data, 32'h4000_0014);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("rr1_read_pre_clr", read_data, 32'h4000_0014);
        tick();
        check("rr1_read_clr", read_data, 32'h0000_0014);
        trig_pulse("rr2", 2'b01, gap);
        wait_done(n);
        check("rr2_done_ch", 32'(done_ch), 32'd0);
        trig_pulse("rr3", 2'b10, gap);
        check("rr3_gap", 32'(gap), 32'd10);

        // Read strobe coincident with the ch1 timeout commit
        repeat (99) tick();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("rf_done", 32'(done), 32'd1);
        check("rf_done_ch", 32'(done_ch), 32'd1);
        tick();
        check("rf_commit_wins", read_data, 32'hC000_0000);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        tick();
        check("rf_clr", read_data, 32'h8000_0000);

        // Reset during MEASURE on ch0
        trig_pulse("rs", 2'b01, gap);
        repeat (2) tick();
        echo[0] = 1'b1;
        repeat (6) tick();
        reset_l = 1'b0;
        tick();
        check("rs_trigger", 32'(trigger), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        check("rs_done_ch", 32'(done_ch), 32'd0);
        check("rs_read_data", read_data, 32'd0);
        reset_l   = 1'b1;
        echo[0]   = 1'b0;
        read_addr = 1'b0;
        tick();
        check("rs_res_cleared", read_data, 32'd0);

        // Enable dropped during TRIG: finish, then stay idle
        n = 0;
        while (trigger == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check("en_trig", 32'(trigger), 32'd1);
        enable = 1'b0;
        n = 0;
        while (trigger != 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check("en_trig_width", 32'(n), 32'd4);
        pulse(0, 2, 10);
        wait_done(n);
        check("en_done", 32'(done), 32'd1);
        tick();
        check("en_read", read_data, 32'h4000_000A);
        seen = 0;
        repeat (60) begin
            if (trigger != 2'b00) seen++;
            tick();
        end
        check("en_no_retrig", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ultra_sonic_array.md
# ultra_sonic_array

Multi-channel ultrasonic ranger controller. It fires `NUM_CH` HC-SR04-style sensors one at a time in round-robin order so that one sensor's echo cannot be picked up by another. Each echo pulse width is measured in clock cycles, and an echo that never arrives or never ends is flagged as a timeout. The block sits between the sensor GPIO pins and the memory-mapped register bus, and keeps a latest-result register per channel that the bus can read.

## Interface
Parameters:
- `NUM_CH`, 4: number of sensor channels (1–16).
- `COUNT_WIDTH`, 24: echo counter and timer width (≤ 30).
- `TRIG_CYCLES`, 500: trigger high time in cycles (10 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_900_000: limit on wait-for-rise plus measure time (38 ms).
- `HOLDOFF_CYCLES`, 3_000_000: quiet time after each channel, before the next trigger (60 ms).

Ports:
- `clk`, in, 1: single clock, 50 MHz.
- `reset_l`, in, 1: reset, synchronous, active-low.
- `enable`, in, 1: run the scan.
- `ch_mask`, in, `NUM_CH`: channels included in the scan.
- `echo`, in, `NUM_CH`: asynchronous echo inputs from GPIO.
- `trigger`, out, `NUM_CH`: one-hot trigger outputs to GPIO.
- `read_addr`, in, `$clog2(NUM_CH)`: selects which channel's result is read.
- `read_en`, in, 1: read strobe; clears the fresh flag of the channel at `read_addr`.
- `read_data`, out, 32: bit31 = timeout, bit30 = fresh, bits[COUNT_WIDTH-1:0] = count, all other bits 0.
- `done`, out, 1: one-cycle pulse when a result is committed.
- `done_ch`, out, `$clog2(NUM_CH)`: channel of the committed result; valid while `done` = 1.

## Operation
- Each echo input passes through a 2-flop synchroniser, giving `echo_s`. Only the current channel's `echo_s` is examined.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF. One shared `timer` of `COUNT_WIDTH` bits and one `count`.
- **IDLE**: if `enable` = 1 and `ch_mask` ≠ 0, select the lowest set mask bit and go to TRIG with `timer` = 0. Otherwise stay in IDLE.
- **TRIG**: `trigger[cur]` = 1. After exactly `TRIG_CYCLES` cycles, go to WAIT_RISE with `timer` = 0.
- **WAIT_RISE**: when `echo_s` = 1, go to MEASURE with `count` = 1.
- **MEASURE**: while `echo_s` = 1, `count` increments, saturating at all-ones. When `echo_s` = 0, commit `{timeout=0, count}` and go to HOLDOFF.
- **Timeout**: `timer` runs through both WAIT_RISE and MEASURE. When it reaches `TIMEOUT_CYCLES` before a commit, commit `{timeout=1, count}` (`count` = 0 if no rise was seen) and go to HOLDOFF.
- **Commit**: write the result register for `cur`, set its fresh bit, and pulse `done` with `done_ch` = `cur`.
- **HOLDOFF**: lasts `HOLDOFF_CYCLES` cycles. Then:
  - if `enable` = 1 and `ch_mask` ≠ 0, choose the next set mask bit above `cur`, wrapping to the lowest set bit, and go to TRIG;
  - otherwise go to IDLE.
- Changes to `ch_mask` and `enable` are sampled only at channel selection. A measurement in progress always completes through HOLDOFF.
- Read and commit to the same channel in the same cycle: the commit wins and fresh = 1.
- A masked-off channel keeps its last result.

## Timing
- Reset value of every output and register is 0: `trigger`, `done`, `done_ch`, `read_data`, all results, and the FSM state (IDLE).
- A reset in mid-operation drops `trigger` on the next edge and discards any partial measurement.
- `trigger` goes high on the first clock edge after leaving IDLE or HOLDOFF, and is high for exactly `TRIG_CYCLES` cycles.
- Echo-to-FSM latency is 2 cycles, from the synchroniser. The reported count equals the number of cycles the synchronised echo was high.
- `done` is high for 1 cycle, on the cycle after the falling edge of `echo_s` or after the timeout.
- `read_data` is registered and appears one cycle after `read_addr` is presented. The fresh bit is cleared on the edge after a `read_en` cycle.

## Structure
- Package `ultra_sonic_pkg` holds:
  - the state enum `us_state_t`;
  - result bit positions `RES_TIMEOUT_BIT` = 31 and `RES_FRESH_BIT` = 30;
  - the result struct `us_result_t`.
- Sub-module `echo_sync`: a 2-flop synchroniser with synchronous active-low reset, instantiated once per channel.
- The round-robin next-channel search is a function in the package.

## Test plan
All scenarios use `NUM_CH`=2, `TRIG_CYCLES`=4, `TIMEOUT_CYCLES`=100, `HOLDOFF_CYCLES`=10.
- **Single measure**: `ch_mask`=2'b01, echo0 rises 5 cycles after trigger falls and stays high 37 cycles -> `trigger[0]` high exactly 4 cycles; `done` with `done_ch`=0; `read_data` = 0x4000_0025.
- **No echo**: echo0 never rises -> `done` 100 cycles after WAIT_RISE entry; `read_data` = 0xC000_0000.
- **Stuck echo**: echo0 stays high -> timeout commit with bit31 = 1 and count < 100; the next trigger follows 10 cycles of HOLDOFF.
- **Round robin**: `ch_mask`=2'b11 -> triggers alternate ch0, ch1, ch0 with exactly 10 quiet cycles between them; `trigger` is never 2'b11.
- **Read/fresh**: `read_en` on ch1 clears bit30; `read_en` in the same cycle as a ch1 commit leaves bit30 = 1.
- **Reset/enable**: `reset_l`=0 during MEASURE -> all outputs 0 next cycle. `enable` dropped during TRIG -> the measurement completes, then the FSM goes to IDLE with no further trigger.
